// File: rtl/tx_frame_arbiter.sv
// Round-robin arbiter sharing one serial transmitter between two frame sources.
// Sends the granted frame byte by byte, then a terminator byte, with a per-byte
// watchdog that aborts the frame and raises a sticky error on timeout.
module tx_frame_arbiter #(
  parameter int unsigned N_BYTES_0      = 6,
  parameter int unsigned N_BYTES_1      = 2,
  parameter logic [7:0]  SEP            = 8'h23,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic [2:0] idx,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] tx_data,
  output logic       partida_tx,
  input  logic       pronto_serial,
  output logic       erro,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    StOcioso    = 4'd0,
    StCarrega   = 4'd2,
    StEnvia     = 4'd3,
    StEspera    = 4'd4,
    StProx      = 4'd5,
    StSeparador = 4'd6,
    StEsperaSep = 4'd7,
    StFim       = 4'd8,
    StErro      = 4'd9
  } state_e;

  localparam logic [2:0]  LAST_IDX_0 = 3'(N_BYTES_0 - 1);
  localparam logic [2:0]  LAST_IDX_1 = 3'(N_BYTES_1 - 1);
  localparam logic [15:0] WD_LAST    = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q;
  logic        sel_q;   // granted requester id
  logic        last_q;  // last served requester id
  logic [15:0] wd_q;

  logic        pick;
  logic [2:0]  last_idx;
  logic        wd_expired;
  logic [15:0] wd_inc;

  // Arbitration pick, end-of-frame index and saturating watchdog increment.
  always_comb begin
    pick       = (req0 && req1) ? ~last_q : req1;
    last_idx   = sel_q ? LAST_IDX_1 : LAST_IDX_0;
    wd_expired = (wd_q == WD_LAST);
    wd_inc     = (wd_q == 16'hFFFF) ? wd_q : wd_q + 16'd1;
  end

  // Debug code mirrors the state encoding; anything else reads as 4'hF.
  always_comb begin
    case (state_q)
      StOcioso, StCarrega, StEnvia, StEspera, StProx,
      StSeparador, StEsperaSep, StFim, StErro: db_estado = state_q;
      default:                                  db_estado = 4'hF;
    endcase
  end

  // Frame sequencer; every output is registered and pulses default low.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StOcioso;
      sel_q      <= 1'b0;
      last_q     <= 1'b1;
      wd_q       <= 16'd0;
      idx        <= 3'd0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      tx_data    <= 8'd0;
      partida_tx <= 1'b0;
      erro       <= 1'b0;
    end else begin
      partida_tx <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      case (state_q)
        StOcioso: begin
          if (req0 || req1) begin
            sel_q   <= pick;
            gnt0    <= ~pick;
            gnt1    <= pick;
            idx     <= 3'd0;
            erro    <= 1'b0;
            state_q <= StCarrega;
          end
        end
        StCarrega: begin
          tx_data    <= sel_q ? data1 : data0;
          partida_tx <= 1'b1;  // visible during StEnvia
          state_q    <= StEnvia;
        end
        StEnvia: begin
          wd_q    <= 16'd0;
          state_q <= StEspera;
        end
        StEspera: begin
          if (pronto_serial)   state_q <= StProx;
          else if (wd_expired) state_q <= StErro;
          else                 wd_q    <= wd_inc;
        end
        StProx: begin
          if (idx == last_idx) begin
            tx_data    <= SEP;
            partida_tx <= 1'b1;  // visible during StSeparador
            state_q    <= StSeparador;
          end else begin
            idx     <= idx + 3'd1;
            state_q <= StCarrega;
          end
        end
        StSeparador: begin
          wd_q    <= 16'd0;
          state_q <= StEsperaSep;
        end
        StEsperaSep: begin
          if (pronto_serial) begin
            done0   <= ~sel_q;  // visible during StFim
            done1   <= sel_q;
            state_q <= StFim;
          end else if (wd_expired) begin
            state_q <= StErro;
          end else begin
            wd_q <= wd_inc;
          end
        end
        StFim: begin
          last_q  <= sel_q;
          gnt0    <= 1'b0;
          gnt1    <= 1'b0;
          state_q <= StOcioso;
        end
        StErro: begin
          erro    <= 1'b1;
          last_q  <= sel_q;
          gnt0    <= 1'b0;
          gnt1    <= 1'b0;
          state_q <= StOcioso;
        end
        default: begin
          gnt0    <= 1'b0;
          gnt1    <= 1'b0;
          state_q <= StOcioso;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Directed bench for tx_frame_arbiter: a transmitter model answers start pulses,
// a scoreboard of expected (owner, byte) starts and done pulses is built from the
// frame contents, and every cycle is checked through tick().
module tb_tx_frame_arbiter;

  localparam int unsigned N0   = 6;
  localparam int unsigned N1   = 2;
  localparam logic [7:0]  SEPB = 8'h23;
  localparam int          T_TX = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] data0, data1;
  logic [2:0] idx;
  logic       gnt0, gnt1, done0, done1, partida_tx, erro;
  logic [7:0] tx_data;
  logic       pronto_serial = 1'b0;
  logic [3:0] db_estado;

  logic [7:0] d0 [8];
  logic [7:0] d1 [8];

  assign data0 = d0[idx];
  assign data1 = d1[idx];

  tx_frame_arbiter #(
    .N_BYTES_0      (N0),
    .N_BYTES_1      (N1),
    .SEP            (SEPB),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .req0          (req0),
    .req1          (req1),
    .data0         (data0),
    .data1         (data1),
    .idx           (idx),
    .gnt0          (gnt0),
    .gnt1          (gnt1),
    .done0         (done0),
    .done1         (done1),
    .tx_data       (tx_data),
    .partida_tx    (partida_tx),
    .pronto_serial (pronto_serial),
    .erro          (erro),
    .db_estado     (db_estado)
  );

  always #5 clock = ~clock;

  // Transmitter model: answers each start T_TX cycles later, optionally goes silent
  // after mute_after starts in a frame, optionally injects stray completions.
  int cnt = 0;
  int np_frame = 0;
  int mute_after = -1;
  bit spur = 1'b0;
  always @(negedge clock) begin
    if (!reset) begin
      cnt = 0;
      np_frame = 0;
      pronto_serial = 1'b0;
    end else begin
      pronto_serial = 1'b0;
      if (!gnt0 && !gnt1) np_frame = 0;
      if (cnt != 0) begin
        cnt--;
        if (cnt == 0) pronto_serial = 1'b1;
      end
      if (partida_tx) begin
        if (mute_after < 0 || np_frame < mute_after) cnt = T_TX;
        np_frame++;
      end
      if (spur && (db_estado == 4'd2 || db_estado == 4'd3)) pronto_serial = 1'b1;
    end
  end

  int vectors = 0;
  int fails = 0;
  int cyc = 0;
  int np = 0;
  int g0cnt = 0, g1cnt = 0;
  logic [8:0] exp_q[$];
  bit         exp_done[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected frame: N data bytes by index, then the terminator.
  task automatic push_frame(input bit id, input bit with_done);
    int n = id ? N1 : N0;
    for (int i = 0; i < n; i++) exp_q.push_back({id, id ? d1[i] : d0[i]});
    exp_q.push_back({id, SEPB});
    if (with_done) exp_done.push_back(id);
  endtask

  // Advance one cycle and check the per-cycle rules against the scoreboard.
  task automatic tick();
    logic [8:0] e;
    bit         d;
    @(negedge clock);
    cyc++;
    if (reset) begin
      chk("grant_exclusive", {31'd0, gnt0 & gnt1}, 32'd0);
      if (gnt0) g0cnt++;
      if (gnt1) g1cnt++;
      if (partida_tx) begin
        np++;
        if (exp_q.size() == 0) begin
          vectors++;
          fails++;
          $display("FAIL unexpected_start: got tx_data %0h, expected no start (cycle %0d)",
                   tx_data, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("start_owner_byte", {22'd0, gnt0, gnt1, tx_data}, {22'd0, ~e[8], e[8], e[7:0]});
        end
      end
      if (done0 || done1) begin
        if (exp_done.size() == 0) begin
          vectors++;
          fails++;
          $display("FAIL unexpected_done: got done %0b%0b, expected none (cycle %0d)",
                   done0, done1, cyc);
        end else begin
          d = exp_done.pop_front();
          chk("done_owner", {30'd0, done0, done1}, {30'd0, ~d, d});
        end
      end
    end
  endtask

  task automatic wait_done(input bit id);
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      tick();
      if (id ? done1 : done0) seen = 1'b1;
    end
    chk("done_within_bound", {31'd0, seen}, 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  function automatic logic [31:0] all_outs();
    return {11'd0, gnt0, gnt1, done0, done1, partida_tx, erro, idx, tx_data, db_estado};
  endfunction

  initial begin
    for (int i = 0; i < 8; i++) begin
      d0[i] = 8'h00;
      d1[i] = 8'h00;
    end

    // Reset values.
    tick();
    tick();
    chk("reset_outputs", all_outs(), 32'd0);
    reset = 1'b1;
    tick();
    chk("idle_after_reset", all_outs(), 32'd0);

    // 1: single requester 0, "123456".
    for (int i = 0; i < 6; i++) d0[i] = 8'h31 + 8'(i);
    g0cnt = 0; g1cnt = 0;
    req0 = 1'b1;
    push_frame(1'b0, 1'b1);
    tick();
    chk("t1_grant_latency", {25'd0, gnt0, gnt1, partida_tx, db_estado}, {25'd0, 3'b100, 4'd2});
    chk("t1_idx_start", {29'd0, idx}, 32'd0);
    tick();
    chk("t1_first_start", {19'd0, partida_tx, tx_data, db_estado}, {19'd0, 1'b1, 8'h31, 4'd3});
    wait_done(1'b0);
    req0 = 1'b0;
    chk("t1_gnt0_cycles", g0cnt, 32'd48);
    chk("t1_gnt1_never", g1cnt, 32'd0);
    chk("t1_bytes_left", exp_q.size(), 32'd0);

    // 2: simultaneous requests held; 0, 1, 0 with idle cycle between.
    do_reset();
    for (int i = 0; i < 2; i++) d1[i] = (i == 0) ? 8'h4F : 8'h4B;
    g0cnt = 0; g1cnt = 0;
    req0 = 1'b1; req1 = 1'b1;
    push_frame(1'b0, 1'b1);
    push_frame(1'b1, 1'b1);
    push_frame(1'b0, 1'b1);
    wait_done(1'b0);
    tick();
    chk("t2_idle_gap_a", {27'd0, gnt0, gnt1, db_estado}, 32'd0);
    tick();
    chk("t2_alternate_to_1", {26'd0, gnt0, gnt1, db_estado}, {26'd0, 2'b01, 4'd2});
    wait_done(1'b1);
    tick();
    tick();
    chk("t2_alternate_to_0", {26'd0, gnt0, gnt1, db_estado}, {26'd0, 2'b10, 4'd2});
    wait_done(1'b0);
    req0 = 1'b0; req1 = 1'b0;
    chk("t2_gnt0_cycles", g0cnt, 32'd96);
    chk("t2_gnt1_cycles", g1cnt, 32'd20);
    chk("t2_bytes_left", exp_q.size(), 32'd0);

    // 3: timeout after the 3rd byte (20 ESPERA cycles, ERRO on the next).
    do_reset();
    begin
      int p = 0;
      bit hit = 1'b0;
      mute_after = 2;
      np = 0;
      req0 = 1'b1;
      exp_q.push_back({1'b0, d0[0]});
      exp_q.push_back({1'b0, d0[1]});
      exp_q.push_back({1'b0, d0[2]});
      for (int i = 0; i < 200 && np < 3; i++) tick();
      p = cyc;
      for (int i = 0; i < 100 && !hit; i++) begin
        tick();
        if (db_estado == 4'd9) hit = 1'b1;
      end
      chk("t3_timeout_latency", cyc - p, 32'd21);
      req0 = 1'b0;
      mute_after = -1;
      tick();
      chk("t3_erro_set", {27'd0, erro, db_estado}, {27'd0, 1'b1, 4'd0});
      tick();
      tick();
      tick();
      chk("t3_erro_sticky", {29'd0, erro, gnt0, gnt1}, {29'd0, 3'b100});
      chk("t3_no_more_bytes", exp_q.size(), 32'd0);
      req1 = 1'b1;
      push_frame(1'b1, 1'b1);
      tick();
      chk("t3_erro_cleared", {29'd0, erro, gnt0, gnt1}, {29'd0, 3'b001});
      wait_done(1'b1);
      req1 = 1'b0;
    end

    // 4: req0 dropped after the 2nd byte; frame still completes.
    do_reset();
    for (int i = 0; i < 6; i++) d0[i] = 8'h41 + 8'(i);
    g0cnt = 0;
    np = 0;
    req0 = 1'b1;
    push_frame(1'b0, 1'b1);
    for (int i = 0; i < 200 && np < 2; i++) tick();
    req0 = 1'b0;
    wait_done(1'b0);
    chk("t4_gnt0_cycles", g0cnt, 32'd48);
    tick();
    tick();
    tick();
    chk("t4_no_regrant", g0cnt, 32'd48);

    // 5: stray completions in CARREGA/ENVIA are ignored.
    do_reset();
    for (int i = 0; i < 6; i++) d0[i] = 8'h61 + 8'(i);
    g0cnt = 0;
    spur = 1'b1;
    req0 = 1'b1;
    push_frame(1'b0, 1'b1);
    wait_done(1'b0);
    req0 = 1'b0;
    spur = 1'b0;
    chk("t5_gnt0_cycles", g0cnt, 32'd48);
    chk("t5_bytes_left", exp_q.size(), 32'd0);

    // 6: reset during ESPERA_SEP, then a fresh requester-1 frame.
    do_reset();
    begin
      bit hit = 1'b0;
      req1 = 1'b1;
      push_frame(1'b1, 1'b0);
      for (int i = 0; i < 200 && !hit; i++) begin
        tick();
        if (db_estado == 4'd7) hit = 1'b1;
      end
      chk("t6_reached_espera_sep", {31'd0, hit}, 32'd1);
      #1 reset = 1'b0;
      #1 chk("t6_async_reset_outputs", all_outs(), 32'd0);
      tick();
      tick();
      reset = 1'b1;
      push_frame(1'b1, 1'b1);
      tick();
      chk("t6_regrant", {23'd0, gnt0, gnt1, idx, db_estado}, {23'd0, 2'b01, 3'd0, 4'd2});
      wait_done(1'b1);
      req1 = 1'b0;
      tick();
    end

    chk("final_bytes_left", exp_q.size(), 32'd0);
    chk("final_dones_left", exp_done.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
